// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: default widths, FSM state encoding
// and the ALU opcode map.
// Latency: n/a (definitions only). Backpressure: n/a.
package alu_arbiter_pkg;

  localparam int WIDTH_DEF = 6;
  localparam int OPW_DEF   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // ALU opcode map
  localparam logic [3:0] OP_ADD  = 4'h0;  // a + b
  localparam logic [3:0] OP_SUB  = 4'h1;  // a - b
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;  // a << b[2:0]
  localparam logic [3:0] OP_SHR  = 4'h9;  // a >> b[2:0], logical
  localparam logic [3:0] OP_SRA  = 4'hA;  // a >>> b[2:0], arithmetic
  localparam logic [3:0] OP_ROL  = 4'hB;  // rotate a left by one
  localparam logic [3:0] OP_NOTA = 4'hC;  // ~a
  localparam logic [3:0] OP_INC  = 4'hD;  // a + 1
  localparam logic [3:0] OP_DEC  = 4'hE;  // a - 1
  localparam logic [3:0] OP_SLTU = 4'hF;  // (a < b) unsigned, result 0/1

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU: WIDTH-bit operands, 16 opcodes, WIDTH-bit result.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: a, b operands; op opcode; y result (carry/overflow dropped, no extension).
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] y
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] sh;
  assign sh = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_NAND: y = ~(a & b);
      OP_XNOR: y = ~(a ^ b);
      OP_SHL:  y = a << sh;
      OP_SHR:  y = a >> sh;
      OP_SRA:  y = $unsigned($signed(a) >>> sh);
      OP_ROL:  y = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_NOTA: y = ~a;
      OP_INC:  y = a + WIDTH'(1);
      OP_DEC:  y = a - WIDTH'(1);
      OP_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; operands are registered before the ALU.
// Latency: accept cycle -> response pulse 2 cycles later; one op per 3 cycles peak.
// Backpressure: reqN_ready only in IDLE for the granted requester; responses cannot be stalled.
// Ports: clk/rst (sync, active-high); req0_*/req1_* valid/ready/a/b/op request channels;
//        rsp0_valid/rsp1_valid one-cycle response pulses sharing rsp_y; busy = FSM not idle.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_y,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             last_grant_q;  // id of the most recent grant; 1 after reset so req0 wins the first tie
  logic             gid_q;         // id owning the operation in flight
  logic [WIDTH-1:0] a_q, b_q, rsp_y_q;
  logic [OPW-1:0]   op_q;
  logic             rsp0_q, rsp1_q;
  logic [WIDTH-1:0] alu_y;

  logic             grant_vld;
  logic             grant_id;

  // Grant decision. Gated by rst so nothing is accepted in a reset cycle.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state_q == S_IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant_q;
      end else if (req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_vld && !grant_id;
  assign req1_ready = grant_vld &&  grant_id;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_vld) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gid_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rsp_y_q      <= '0;
      rsp0_q       <= 1'b0;
      rsp1_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
      if (grant_vld) begin
        gid_q        <= grant_id;
        last_grant_q <= grant_id;
        a_q          <= grant_id ? req1_a  : req0_a;
        b_q          <= grant_id ? req1_b  : req0_b;
        op_q         <= grant_id ? req1_op : req0_op;
      end
      // Capturing at the EXEC->RESP edge makes the pulse coincide with the RESP cycle.
      if (state_q == S_EXEC) begin
        rsp_y_q <= alu_y;
        rsp0_q  <= !gid_q;
        rsp1_q  <=  gid_q;
      end
    end
  end

  alu_arbiter_alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y)
  );

  assign rsp_y      = rsp_y_q;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked cycle by cycle
// against a transaction-level model (accept times, round-robin pointer, response queue).
module tb_alu_arbiter;

  localparam int WIDTH = 6;
  localparam int OPW   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             v0, v1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic [OPW-1:0]   op0, op1;
  logic             req0_ready, req1_ready;
  logic             rsp0_valid, rsp1_valid, busy;
  logic [WIDTH-1:0] rsp_y;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (v0),
    .req0_ready (req0_ready),
    .req0_a     (a0),
    .req0_b     (b0),
    .req0_op    (op0),
    .req1_valid (v1),
    .req1_ready (req1_ready),
    .req1_a     (a1),
    .req1_b     (b1),
    .req1_op    (op1),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_y      (rsp_y),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int cyc      = 0;
  int last_acc = -100;
  int mlast    = 1;
  int m_y      = 0;
  bit prev_rst = 1'b0;
  int q_due[$], q_id[$], q_y[$];
  bit xfer0, xfer1;
  int acc_log[$], acc_cyc[$];   // accepts as seen on the DUT ports

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic int alu_ref(input int op, input int a, input int b);
    int sa;
    case (op)
      0:  return (a + b) & 63;
      1:  return (a - b) & 63;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~(a | b) & 63;
      6:  return ~(a & b) & 63;
      7:  return ~(a ^ b) & 63;
      8:  return (a << (b % 8)) & 63;
      9:  return a >> (b % 8);
      10: begin
        sa = (a >= 32) ? a - 64 : a;
        return (sa >>> (b % 8)) & 63;
      end
      11: return ((a << 1) | (a >> 5)) & 63;
      12: return ~a & 63;
      13: return (a + 1) & 63;
      14: return (a - 1) & 63;
      default: return (a < b) ? 1 : 0;
    endcase
  endfunction

  // One clock cycle: check outputs at the negedge, then return 1 time unit after the next posedge.
  task automatic step();
    int g;
    bit e0, e1;
    @(negedge clk);
    xfer0 = 1'b0;
    xfer1 = 1'b0;
    if (!rst && req0_ready && v0) begin acc_log.push_back(0); acc_cyc.push_back(cyc); end
    if (!rst && req1_ready && v1) begin acc_log.push_back(1); acc_cyc.push_back(cyc); end
    if (rst) begin
      check("ready0_in_rst", req0_ready, 0);
      check("ready1_in_rst", req1_ready, 0);
      if (prev_rst) begin
        check("busy_rst", busy, 0);
        check("rsp0_rst", rsp0_valid, 0);
        check("rsp1_rst", rsp1_valid, 0);
        check("rsp_y_rst", rsp_y, 0);
      end
      q_due.delete(); q_id.delete(); q_y.delete();
      last_acc = -100;
      mlast    = 1;
      m_y      = 0;
      prev_rst = 1'b1;
    end else begin
      e0 = 1'b0;
      e1 = 1'b0;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        if (q_id[0] == 0) e0 = 1'b1; else e1 = 1'b1;
        m_y = q_y[0];
        void'(q_due.pop_front()); void'(q_id.pop_front()); void'(q_y.pop_front());
      end
      check("rsp0_valid", rsp0_valid, e0);
      check("rsp1_valid", rsp1_valid, e1);
      check("rsp_y", rsp_y, m_y);
      check("busy", busy, ((cyc - last_acc) == 1 || (cyc - last_acc) == 2));
      g = -1;
      if (cyc - last_acc >= 3) begin
        if (v0 && v1)  g = 1 - mlast;
        else if (v0)   g = 0;
        else if (v1)   g = 1;
      end
      check("req0_ready", req0_ready, (g == 0));
      check("req1_ready", req1_ready, (g == 1));
      if (g >= 0) begin
        last_acc = cyc;
        mlast    = g;
        q_due.push_back(cyc + 2);
        q_id.push_back(g);
        q_y.push_back(g == 0 ? alu_ref(int'(op0), int'(a0), int'(b0))
                             : alu_ref(int'(op1), int'(a1), int'(b1)));
        xfer0 = (g == 0);
        xfer1 = (g == 1);
      end
      prev_rst = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic wait_xfer(input int id);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < 20) begin
      step();
      n++;
      hit = (id == 0) ? xfer0 : xfer1;
    end
    if (!hit) check("xfer_timeout", 0, 1);
  endtask

  task automatic rand0(); a0 = WIDTH'($urandom); b0 = WIDTH'($urandom); op0 = OPW'($urandom); endtask
  task automatic rand1(); a1 = WIDTH'($urandom); b1 = WIDTH'($urandom); op1 = OPW'($urandom); endtask

  initial begin
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0;
    a0 = '0; b0 = '0; op0 = '0;
    a1 = '0; b1 = '0; op1 = '0;

    // 1: reset held 2 cycles starting in EXEC aborts the operation
    reset_dut(2);
    v0 = 1'b1; a0 = 6'd33; b0 = 6'd9; op0 = 4'h0;
    wait_xfer(0);
    v0 = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (4) step();

    // 2: requester 0 alone, every opcode
    for (int op = 0; op < 16; op++) begin
      v0 = 1'b1; a0 = 6'b001100; b0 = 6'b000101; op0 = OPW'(op);
      wait_xfer(0);
      v0 = 1'b0; a0 = WIDTH'($urandom);
      repeat (3) step();
    end

    // 3: requester 1 alone, every opcode
    for (int op = 0; op < 16; op++) begin
      v1 = 1'b1; a1 = 6'b000111; b1 = 6'b001011; op1 = OPW'(op);
      wait_xfer(1);
      v1 = 1'b0; b1 = WIDTH'($urandom);
      repeat (3) step();
    end

    // 4: both valid from reset -> 0,1,0,1... one accept every 3 cycles
    reset_dut(2);
    acc_log.delete(); acc_cyc.delete();
    rand0(); rand1();
    v0 = 1'b1; v1 = 1'b1;
    for (int n = 0; n < 60 && acc_log.size() < 12; n++) begin
      step();
      if (xfer0) rand0();
      if (xfer1) rand1();
    end
    v0 = 1'b0; v1 = 1'b0;
    check("t4_accepts", acc_log.size(), 12);
    for (int i = 0; i < acc_log.size(); i++) begin
      check("t4_order", acc_log[i], i % 2);
      if (i > 0) check("t4_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
    end
    repeat (3) step();

    // 5: req1 pulse outside IDLE is lost; pulse in IDLE after req0 served wins
    reset_dut(2);
    rand0(); v0 = 1'b1;
    wait_xfer(0);
    acc_log.delete(); acc_cyc.delete();
    rand1(); v1 = 1'b1;
    step();                 // EXEC: req1 valid, not ready
    v1 = 1'b0;
    step();                 // RESP
    step();                 // IDLE: only req0 valid
    check("t5_drop_n", acc_log.size(), 1);
    if (acc_log.size() > 0) check("t5_drop_id", acc_log[0], 0);
    rand0();
    step();                 // EXEC
    step();                 // RESP
    rand1(); v1 = 1'b1;
    step();                 // IDLE: both valid, last grant was 0
    v1 = 1'b0;
    check("t5_win_n", acc_log.size(), 2);
    if (acc_log.size() > 1) check("t5_win_id", acc_log[1], 1);
    v0 = 1'b0;
    repeat (3) step();

    // 6: operand changes after accept do not reach the ALU
    v0 = 1'b1; a0 = 6'd10; b0 = 6'd20; op0 = 4'h0;
    wait_xfer(0);
    v0 = 1'b0; a0 = 6'd63; b0 = 6'd1;
    step();                 // EXEC with new a0 on the port
    step();                 // RESP: model expects 30
    check("t6_rsp_y", rsp_y, 30);
    step();

    // random traffic with occasional resets
    reset_dut(2);
    for (int n = 0; n < 2500; n++) begin
      if (xfer0) begin
        v0 = 1'($urandom); rand0();
      end else if (!v0 && $urandom_range(0, 2) == 0) begin
        v0 = 1'b1; rand0();
      end else if (v0 && $urandom_range(0, 15) == 0) begin
        v0 = 1'b0;
      end
      if (xfer1) begin
        v1 = 1'($urandom); rand1();
      end else if (!v1 && $urandom_range(0, 2) == 0) begin
        v1 = 1'b1; rand1();
      end else if (v1 && $urandom_range(0, 15) == 0) begin
        v1 = 1'b0;
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
